gemm_mvm_seq: RTL
=================

GEMM_MVM_SEQ -- requirements
Module: gemm_mvm_seq

Interface
REQ-001 SHALL have parameter IN_BIT, default 6: signed width of each vector and weight element.
REQ-002 SHALL have parameter VEC_LEN, default 32: elements per input vector and per weight row.
REQ-003 SHALL have parameter OUT_CH, default 4: number of output channels (weight rows).
REQ-004 SHALL have parameter LANES, default 8: multiply-accumulates per cycle; VEC_LEN SHALL be a multiple of LANES.
REQ-005 SHALL have parameter OUT_BIT, default 8: signed width of each result element.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port w_we, input, 1: weight write strobe.
REQ-009 SHALL have port w_addr, input, clog2(OUT_CH*VEC_LEN): weight index, row-major (row*VEC_LEN+col).
REQ-010 SHALL have port w_data, input, IN_BIT: signed weight value.
REQ-011 SHALL have port in_valid, input, 1: vector_in holds a valid vector.
REQ-012 SHALL have port in_ready, output, 1: block accepts a vector.
REQ-013 SHALL have port vector_in, input, VEC_LEN*IN_BIT: element 0 in the MSBs.
REQ-014 SHALL have port out_valid, output, 1: result holds a valid output.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-016 SHALL have port result, output, OUT_CH*OUT_BIT: channel 0 in the MSBs.

Function
REQ-017 SHALL run a three-state FSM: IDLE -> COMPUTE on in_valid&&in_ready; COMPUTE -> DONE after the last beat; DONE -> IDLE on out_valid&&out_ready.
REQ-018 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-019 SHALL capture vector_in into an internal register on acceptance, so later changes to vector_in have no effect.
REQ-020 SHALL process, in COMPUTE, LANES elements of one channel per cycle: channel-major, column chunks ascending, for OUT_CH*VEC_LEN/LANES cycles (16 at defaults).
REQ-021 SHALL hold a full-precision signed accumulator of 2*IN_BIT+clog2(VEC_LEN) bits, cleared at the start of each channel.
REQ-022 SHALL saturate each channel sum to the signed OUT_BIT range [-2^(OUT_BIT-1), 2^(OUT_BIT-1)-1] before storing it into result.
REQ-023 SHALL assert out_valid exactly OUT_CH*VEC_LEN/LANES+1 cycles after the acceptance edge (17 at defaults).
REQ-024 SHALL hold result and out_valid stable in DONE until out_ready=1; back-pressure of any length is legal.
REQ-025 SHALL leave result unchanged after the DONE->IDLE handshake until the next DONE.
REQ-026 SHALL write weights only when w_we=1 in IDLE; w_we in COMPUTE or DONE SHALL be ignored, so weights are stable during a computation.
REQ-027 SHALL give in_valid acceptance priority over a same-cycle w_we in IDLE: the write completes and the computation uses the pre-write weight for that address.
REQ-028 SHALL allow back-to-back operation: in_ready reasserts in the cycle after the DONE handshake.

Reset
REQ-029 SHALL, on rst_n=0 at any time, immediately force the FSM to IDLE, in_ready=1 (once rst_n=1), out_valid=0, result=0, accumulator=0, and all weights=0.
REQ-030 SHALL abandon an in-progress computation on reset mid-COMPUTE or mid-DONE, with no result produced.

Configuration
REQ-031 SHALL, when macro GEMM_RELU_EN is defined, clamp each saturated channel result below zero to 0.
REQ-032 SHALL, when GEMM_RELU_EN is undefined, output signed saturated results with no clamping.

Verification (defaults)
REQ-033 Basic sum: load all weights=1, vector all 1 -> out_valid at acceptance+17 cycles; every channel = 32.
REQ-034 Positive saturation: weights all 31, vector all 31 (sum 30752) -> every channel = 127.
REQ-035 Negative saturation and ReLU: weights all 31, vector all -32 -> every channel = -128 without GEMM_RELU_EN, 0 with it.
REQ-036 Channel weights and write lockout:
- Row r of the weights = r+1, vector all 2 -> channels 64/127/127/127.
- w_we pulses during COMPUTE leave the weights unchanged.
REQ-037 Back-pressure and reset:
- Hold out_ready=0 for 10 cycles -> result stable and in_ready=0 throughout.
- rst_n=0 at COMPUTE cycle 5 -> out_valid=0, result=0, in_ready=1 after release.

Source files
------------

// File: rtl/gemm_mvm_seq.sv
// Sequential signed matrix-vector multiply: OUT_CH weight rows times one captured vector, LANES MACs per cycle.
// Optional macro GEMM_RELU_EN clamps negative saturated channel results to zero.
module gemm_mvm_seq #(
    parameter int IN_BIT  = 6,
    parameter int VEC_LEN = 32,
    parameter int OUT_CH  = 4,
    parameter int LANES   = 8,
    parameter int OUT_BIT = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              w_we,
    input  logic [$clog2(OUT_CH*VEC_LEN)-1:0] w_addr,
    input  logic [IN_BIT-1:0]                 w_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [VEC_LEN*IN_BIT-1:0]         vector_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_CH*OUT_BIT-1:0]         result
);

    localparam int NW     = OUT_CH * VEC_LEN;
    localparam int AW     = $clog2(NW);
    localparam int VW     = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int CHUNKS = VEC_LEN / LANES;
    localparam int CK_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int CH_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int ACC_W  = 2 * IN_BIT + $clog2(VEC_LEN);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_BIT - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    function automatic logic [OUT_BIT-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic [OUT_BIT-1:0] r;
`ifdef GEMM_RELU_EN
        if (v[ACC_W-1]) begin
            r = '0;
        end else if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_BIT-1:0];
        end else begin
            r = v[OUT_BIT-1:0];
        end
`else
        if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_BIT-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[OUT_BIT-1:0];
        end else begin
            r = v[OUT_BIT-1:0];
        end
`endif
        return r;
    endfunction

    state_t                    state_r;
    logic                      in_ready_r;
    logic                      out_valid_r;
    logic [CH_W-1:0]           ch_r;
    logic [CK_W-1:0]           chunk_r;
    logic signed [IN_BIT-1:0]  vec_r   [VEC_LEN];
    logic signed [IN_BIT-1:0]  w_mem_r [NW];
    logic                      pend_we_r;
    logic [AW-1:0]             pend_addr_r;
    logic [IN_BIT-1:0]         pend_data_r;
    logic signed [ACC_W-1:0]   prod_s  [LANES];
    logic signed [ACC_W-1:0]   lane_sum_s;
    logic signed [ACC_W-1:0]   acc_next_s;
    logic signed [ACC_W-1:0]   part_r;
    logic signed [ACC_W-1:0]   acc_r;
    logic                      part_vld_r;
    logic                      part_first_r;
    logic                      part_last_r;
    logic [CH_W-1:0]           part_ch_r;
    logic [OUT_CH*OUT_BIT-1:0] result_r;
    logic                      accept_s;
    logic                      done_hs_s;
    logic                      last_chunk_s;
    logic                      last_ch_s;

    assign accept_s     = in_ready_r && in_valid;
    assign done_hs_s    = (state_r == S_DONE) && out_valid_r && out_ready;
    assign last_chunk_s = (chunk_r == CK_W'(CHUNKS - 1));
    assign last_ch_s    = (ch_r == CH_W'(OUT_CH - 1));

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [VW-1:0] col_s;
        logic [AW-1:0] widx_s;
        assign col_s     = VW'(int'(chunk_r) * LANES + l);
        assign widx_s    = AW'(int'(ch_r) * VEC_LEN + int'(chunk_r) * LANES + l);
        assign prod_s[l] = w_mem_r[widx_s] * vec_r[col_s];
    end

    // Lane adder tree and accumulate-or-restart for the beat leaving the product register.
    always_comb begin
        lane_sum_s = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum_s = lane_sum_s + prod_s[l];
        end
        acc_next_s = part_first_r ? part_r : (acc_r + part_r);
    end

    // Control FSM: vector capture, beat sequencing and the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            ch_r         <= '0;
            chunk_r      <= '0;
            part_r       <= '0;
            part_vld_r   <= 1'b0;
            part_first_r <= 1'b0;
            part_last_r  <= 1'b0;
            part_ch_r    <= '0;
            for (int i = 0; i < VEC_LEN; i++) begin
                vec_r[i] <= '0;
            end
        end else begin
            part_vld_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_r    <= S_COMPUTE;
                        in_ready_r <= 1'b0;
                        ch_r       <= '0;
                        chunk_r    <= '0;
                        for (int i = 0; i < VEC_LEN; i++) begin
                            vec_r[i] <= vector_in[(VEC_LEN-1-i)*IN_BIT +: IN_BIT];
                        end
                    end
                end
                S_COMPUTE: begin
                    part_r       <= lane_sum_s;
                    part_vld_r   <= 1'b1;
                    part_first_r <= (chunk_r == CK_W'(0));
                    part_last_r  <= last_chunk_s;
                    part_ch_r    <= ch_r;
                    if (last_chunk_s) begin
                        chunk_r <= '0;
                        ch_r    <= ch_r + CH_W'(1);
                        if (last_ch_s) begin
                            state_r <= S_DONE;
                        end
                    end else begin
                        chunk_r <= chunk_r + CK_W'(1);
                    end
                end
                S_DONE: begin
                    // The final beat drains from the product register on the first DONE cycle.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        state_r     <= S_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Channel accumulator and saturated result store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= '0;
            result_r <= '0;
        end else if (part_vld_r) begin
            acc_r <= acc_next_s;
            if (part_last_r) begin
                result_r[(OUT_CH-1-int'(part_ch_r))*OUT_BIT +: OUT_BIT] <= sat(acc_next_s);
            end
        end
    end

    // Weight store; a write colliding with acceptance is held until the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                w_mem_r[i] <= '0;
            end
            pend_we_r   <= 1'b0;
            pend_addr_r <= '0;
            pend_data_r <= '0;
        end else if (accept_s) begin
            if (w_we) begin
                pend_we_r   <= 1'b1;
                pend_addr_r <= w_addr;
                pend_data_r <= w_data;
            end
        end else if ((state_r == S_IDLE) && w_we) begin
            w_mem_r[w_addr] <= w_data;
        end else if (done_hs_s && pend_we_r) begin
            w_mem_r[pend_addr_r] <= pend_data_r;
            pend_we_r            <= 1'b0;
        end
    end

endmodule
